// File: rtl/led_level_meter.sv
// LED bar driver: peak-hold/decay audio meter or static volume-pot bar.
// Optional peak dot tracker enabled by defining LED_PEAK_DOT_EN.
`timescale 1ns/1ps
module led_level_meter #(
   parameter int unsigned SAMPLE_W    = 16,
   parameter int unsigned VOL_W       = 12,
   parameter int unsigned NUM_LED     = 8,
   parameter int unsigned HOLD_SMPL   = 4800,
   parameter int unsigned DECAY_SHIFT = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       valid,
   input  logic signed [SAMPLE_W-1:0] lft_smpl,
   input  logic signed [SAMPLE_W-1:0] rht_smpl,
   input  logic        [VOL_W-1:0]    volume,
   input  logic                       mode,
   output logic        [NUM_LED-1:0]  LED
);

   localparam int unsigned LVL_W  = SAMPLE_W - 1;
   localparam int unsigned LIT_W  = $clog2(NUM_LED + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD_SMPL + 1);

   typedef enum logic {StDecay, StHold} state_t;

   state_t             state_q;
   logic [LVL_W-1:0]   mag_q;
   logic               mag_vld_q;
   logic [LVL_W-1:0]   level_q;
   logic [HOLD_W-1:0]  hold_cnt_q;
   logic [NUM_LED-1:0] led_q;

   logic [LVL_W-1:0]   lft_abs, rht_abs;
   logic [LVL_W-1:0]   decay_step, decay_lvl;
   logic [LVL_W+4:0]   lvl_prod, lvl_quot;
   logic [VOL_W+4:0]   vol_prod, vol_quot;
   logic [LIT_W-1:0]   lit_lvl, lit_vol, lit_sel;
   logic [NUM_LED-1:0] led_d;

   // |x| with the most-negative code saturated to the largest positive magnitude.
   function automatic logic [LVL_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] s);
      logic [SAMPLE_W-1:0] neg;
      neg = ~s + 1'b1;
      if (!s[SAMPLE_W-1]) begin
         return s[LVL_W-1:0];
      end else if (neg[SAMPLE_W-1]) begin
         return {LVL_W{1'b1}};
      end else begin
         return neg[LVL_W-1:0];
      end
   endfunction

   function automatic logic [NUM_LED-1:0] therm(input logic [LIT_W-1:0] n);
      logic [NUM_LED-1:0] t;
      t = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         t[i] = (LIT_W'(i) < n);
      end
      return t;
   endfunction

   always_comb begin
      lft_abs = sat_abs(lft_smpl);
      rht_abs = sat_abs(rht_smpl);
   end

   // Stage 1: peak magnitude of the stereo pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_q     <= '0;
         mag_vld_q <= 1'b0;
      end else begin
         mag_vld_q <= valid;
         if (valid) begin
            mag_q <= (lft_abs > rht_abs) ? lft_abs : rht_abs;
         end
      end
   end

   always_comb begin
      decay_step = level_q >> DECAY_SHIFT;
      if (decay_step == '0) begin
         decay_step = LVL_W'(1);
      end
      decay_lvl = level_q - decay_step;
      if (decay_lvl < mag_q) begin
         decay_lvl = mag_q;
      end
   end

   // Stage 2: attack/hold/decay tracker, advanced only by sample strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StDecay;
         level_q    <= '0;
         hold_cnt_q <= '0;
      end else if (mag_vld_q) begin
         if (mag_q >= level_q) begin
            level_q    <= mag_q;
            hold_cnt_q <= HOLD_W'(HOLD_SMPL);
            state_q    <= StHold;
         end else begin
            case (state_q)
               StHold: begin
                  if (hold_cnt_q > HOLD_W'(1)) begin
                     hold_cnt_q <= hold_cnt_q - 1'b1;
                  end else begin
                     hold_cnt_q <= '0;
                     state_q    <= StDecay;
                  end
               end
               StDecay: begin
                  level_q <= decay_lvl;
               end
               default: begin
                  state_q <= StDecay;
               end
            endcase
         end
      end
   end

   // Full-width products so the scale-by-(NUM_LED+1) never truncates before the shift.
   always_comb begin
      lvl_prod = (LVL_W+5)'(level_q) * (LVL_W+5)'(NUM_LED + 1);
      lvl_quot = lvl_prod >> LVL_W;
      if (lvl_quot > (LVL_W+5)'(NUM_LED)) begin
         lit_lvl = LIT_W'(NUM_LED);
      end else begin
         lit_lvl = LIT_W'(lvl_quot);
      end

      vol_prod = (VOL_W+5)'(volume) * (VOL_W+5)'(NUM_LED + 1);
      vol_quot = vol_prod >> VOL_W;
      if (vol_quot > (VOL_W+5)'(NUM_LED)) begin
         lit_vol = LIT_W'(NUM_LED);
      end else begin
         lit_vol = LIT_W'(vol_quot);
      end

      lit_sel = mode ? lit_vol : lit_lvl;
   end

`ifdef LED_PEAK_DOT_EN
   localparam int unsigned PK_W = $clog2(4 * HOLD_SMPL + 1);

   logic [LIT_W-1:0]   pk_dot_pos_q;
   logic [PK_W-1:0]    pk_cnt_q;
   logic [NUM_LED-1:0] dot;

   // Long hold on the highest bar reached, then step down one LED per HOLD_SMPL strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pk_dot_pos_q <= '0;
         pk_cnt_q     <= '0;
      end else if (lit_lvl > pk_dot_pos_q) begin
         pk_dot_pos_q <= lit_lvl;
         pk_cnt_q     <= PK_W'(4 * HOLD_SMPL);
      end else if (mag_vld_q && (pk_dot_pos_q != '0)) begin
         if (pk_cnt_q > PK_W'(1)) begin
            pk_cnt_q <= pk_cnt_q - 1'b1;
         end else begin
            pk_dot_pos_q <= pk_dot_pos_q - 1'b1;
            pk_cnt_q     <= PK_W'(HOLD_SMPL);
         end
      end
   end

   always_comb begin
      dot = '0;
      if (!mode && (pk_dot_pos_q > lit_lvl)) begin
         for (int i = 0; i < NUM_LED; i++) begin
            dot[i] = (pk_dot_pos_q == LIT_W'(i + 1));
         end
      end
      led_d = therm(lit_sel) | dot;
   end
`else
   always_comb begin
      led_d = therm(lit_sel);
   end
`endif

   // Stage 3: registered LED drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign LED = led_q;

endmodule
